// File: rtl/keccak_pkg.sv
// rtl/keccak_pkg.sv - shared lane width, state type and pad constants for the absorb controller
package keccak_pkg;

    // Lane width in bits and bytes per lane
    localparam int w   = 64;
    localparam int BPW = w / 8;

    // Final pad bit of the rate block, lands in the top byte of the last lane
    localparam logic [7:0] PAD_END    = 8'h80;
    // SHAKE domain separation byte
    localparam logic [7:0] DS_DEFAULT = 8'h1F;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_ABSORB = 2'd1,
        ST_PAD    = 2'd2,
        ST_PERM   = 2'd3
    } absorb_state_t;

endpackage

// File: rtl/absorb_byte_counter.sv
// rtl/absorb_byte_counter.sv - per-message remaining byte count with final-word detection
module absorb_byte_counter
    import keccak_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   load,
    input  logic [WIDTH-1:0]       load_val,
    input  logic                   dec,
    output logic                   final_word,
    output logic [$clog2(BPW):0]   final_bytes,
    output logic                   has_data
);

    localparam int FBW = $clog2(BPW) + 1;
    localparam logic [WIDTH-1:0] BPW_W = WIDTH'(BPW);

    logic [WIDTH-1:0] bytes_q, bytes_d;

    // Next count: reload on a new message, otherwise drop one word's worth, never below zero
    always_comb begin
        bytes_d = bytes_q;
        if (load) begin
            bytes_d = load_val;
        end else if (dec) begin
            bytes_d = (bytes_q > BPW_W) ? (bytes_q - BPW_W) : '0;
        end
    end

    // Count register
    always_ff @(posedge clk) begin
        if (rst) begin
            bytes_q <= '0;
        end else begin
            bytes_q <= bytes_d;
        end
    end

    assign final_word  = (bytes_q <= BPW_W);
    assign final_bytes = final_word ? bytes_q[FBW-1:0] : FBW'(BPW);
    assign has_data    = (bytes_q != '0);

endmodule

// File: rtl/keccak_absorb_ctrl.sv
// rtl/keccak_absorb_ctrl.sv - absorb sequencer, padding enabled by KECCAK_ABSORB_PAD_EN
module keccak_absorb_ctrl
    import keccak_pkg::*;
#(
    parameter int         WIDTH      = 32,
    parameter int         RATE_LANES = 21,
    parameter logic [7:0] DS         = DS_DEFAULT
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          start,
    input  logic [WIDTH-1:0]              msg_len,
    output logic                          busy,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [w-1:0]                  in_data,
    output logic                          absorb_valid,
    output logic [$clog2(RATE_LANES)-1:0] absorb_lane,
    output logic [w-1:0]                  absorb_data,
    output logic                          perm_start,
    input  logic                          perm_done,
    output logic                          done
);

    localparam int LW  = $clog2(RATE_LANES);
    localparam int FBW = $clog2(BPW) + 1;
    localparam logic [LW-1:0] LAST_LANE = LW'(RATE_LANES - 1);

    absorb_state_t  state_q;
    logic [LW-1:0]  lane_q;
    logic           ds_pending_q;
    logic           pad_done_q;
    logic           perm_start_q;
    logic           done_q;

    logic           accept;
    logic           perm_ack;
    logic           last_lane;
    logic           final_word;
    logic [FBW-1:0] final_bytes;
    logic           has_data;
    logic [w-1:0]   word_data;

    assign accept    = (state_q == ST_ABSORB) && in_valid;
    // The launch cycle itself never completes a permutation
    assign perm_ack  = (state_q == ST_PERM) && perm_done && !perm_start_q;
    assign last_lane = (lane_q == LAST_LANE);

    absorb_byte_counter #(.WIDTH(WIDTH)) u_byte_counter (
        .clk         (clk),
        .rst         (rst),
        .load        ((state_q == ST_IDLE) && start),
        .load_val    (msg_len),
        .dec         (accept),
        .final_word  (final_word),
        .final_bytes (final_bytes),
        .has_data    (has_data)
    );

    // Lane value: raw input word, or masked/padded final word, or a pure pad lane
    always_comb begin
        word_data = '0;
        if (state_q == ST_ABSORB) begin
            word_data = in_data;
`ifdef KECCAK_ABSORB_PAD_EN
            if (final_word) begin
                for (int b = 0; b < BPW; b++) begin
                    if (b >= int'(final_bytes)) word_data[8*b +: 8] = 8'h00;
                    if (b == int'(final_bytes)) word_data[8*b +: 8] = DS;
                end
                if ((final_bytes != FBW'(BPW)) && last_lane) begin
                    word_data[w-1 -: 8] = word_data[w-1 -: 8] ^ PAD_END;
                end
            end
`endif
        end
`ifdef KECCAK_ABSORB_PAD_EN
        else if (state_q == ST_PAD) begin
            if (ds_pending_q) word_data[7:0] = DS;
            if (last_lane) word_data[w-1 -: 8] = word_data[w-1 -: 8] ^ PAD_END;
        end
`else
    end

    logic unused_pad_bits;
    assign unused_pad_bits = ^{final_bytes, DS, PAD_END, ds_pending_q};

    always_comb begin
`endif
    end

    assign busy         = (state_q != ST_IDLE);
    assign in_ready     = (state_q == ST_ABSORB);
    assign absorb_valid = accept || (state_q == ST_PAD);
    assign absorb_lane  = absorb_valid ? lane_q : '0;
    assign absorb_data  = absorb_valid ? word_data : '0;
    assign perm_start   = perm_start_q;
    assign done         = done_q;

    // Sequencer: lane bookkeeping, pad tracking and permutation handshake
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= ST_IDLE;
            lane_q       <= '0;
            ds_pending_q <= 1'b0;
            pad_done_q   <= 1'b0;
            perm_start_q <= 1'b0;
            done_q       <= 1'b0;
        end else begin
            perm_start_q <= 1'b0;
            done_q       <= 1'b0;
            case (state_q)
                ST_IDLE: begin
                    if (start) begin
                        lane_q       <= '0;
                        pad_done_q   <= 1'b0;
                        ds_pending_q <= 1'b0;
                        if (msg_len == '0) begin
`ifdef KECCAK_ABSORB_PAD_EN
                            state_q      <= ST_PAD;
                            ds_pending_q <= 1'b1;
`else
                            done_q       <= 1'b1;
`endif
                        end else begin
                            state_q <= ST_ABSORB;
                        end
                    end
                end
                ST_ABSORB: begin
                    if (accept) begin
                        if (last_lane) begin
                            lane_q       <= '0;
                            state_q      <= ST_PERM;
                            perm_start_q <= 1'b1;
                        end else begin
                            lane_q <= lane_q + LW'(1);
                        end
`ifdef KECCAK_ABSORB_PAD_EN
                        if (final_word) begin
                            if (final_bytes == FBW'(BPW)) ds_pending_q <= 1'b1;
                            else if (last_lane)           pad_done_q   <= 1'b1;
                            if (!last_lane) state_q <= ST_PAD;
                        end
`else
                        if (final_word) begin
                            pad_done_q   <= 1'b1;
                            lane_q       <= '0;
                            state_q      <= ST_PERM;
                            perm_start_q <= 1'b1;
                        end
`endif
                    end
                end
                ST_PAD: begin
                    ds_pending_q <= 1'b0;
                    if (last_lane) begin
                        pad_done_q   <= 1'b1;
                        lane_q       <= '0;
                        state_q      <= ST_PERM;
                        perm_start_q <= 1'b1;
                    end else begin
                        lane_q <= lane_q + LW'(1);
                    end
                end
                default: begin
                    if (perm_ack) begin
                        if (pad_done_q) begin
                            done_q  <= 1'b1;
                            state_q <= ST_IDLE;
                        end else if (has_data) begin
                            state_q <= ST_ABSORB;
                        end
`ifdef KECCAK_ABSORB_PAD_EN
                        else begin
                            state_q <= ST_PAD;
                        end
`endif
                    end
                end
            endcase
        end
    end

endmodule

// File: tb/tb_keccak_absorb_ctrl.sv
// tb/tb_keccak_absorb_ctrl.sv - randomized self-checking bench for keccak_absorb_ctrl
module tb_keccak_absorb_ctrl;

    localparam int W  = 64;
    localparam int RL = 21;
    localparam int R  = RL * 8;
`ifdef KECCAK_ABSORB_PAD_EN
    localparam bit PAD = 1'b1;
`else
    localparam bit PAD = 1'b0;
`endif

    logic        clk;
    logic        rst;
    logic        start;
    logic [31:0] msg_len;
    logic        busy;
    logic        in_valid;
    logic        in_ready;
    logic [63:0] in_data;
    logic        absorb_valid;
    logic [4:0]  absorb_lane;
    logic [63:0] absorb_data;
    logic        perm_start;
    logic        perm_done;
    logic        done;

    int checks   = 0;
    int failures = 0;

    logic [63:0] words [0:63];
    logic [4:0]  exp_lane [$];
    logic [63:0] exp_data [$];
    int          exp_perms;

    keccak_absorb_ctrl #(.WIDTH(32), .RATE_LANES(RL), .DS(8'h1F)) dut (
        .clk          (clk),
        .rst          (rst),
        .start        (start),
        .msg_len      (msg_len),
        .busy         (busy),
        .in_valid     (in_valid),
        .in_ready     (in_ready),
        .in_data      (in_data),
        .absorb_valid (absorb_valid),
        .absorb_lane  (absorb_lane),
        .absorb_data  (absorb_data),
        .perm_start   (perm_start),
        .perm_done    (perm_done),
        .done         (done)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Reference: pad the message as a byte string, then slice into lanes
    task automatic build_model(input int len);
        int nw;
        int p;
        logic [7:0]  pb [0:1023];
        logic [63:0] d;
        nw = (len + 7) / 8;
        exp_lane.delete();
        exp_data.delete();
        if (PAD) begin
            p = (len / R + 1) * R;
            for (int j = 0; j < p; j++) pb[j] = (j < len) ? words[j/8][8*(j%8) +: 8] : 8'h00;
            pb[len]   = pb[len] ^ 8'h1F;
            pb[p-1]   = pb[p-1] ^ 8'h80;
            for (int i = 0; i < p / 8; i++) begin
                for (int k = 0; k < 8; k++) d[8*k +: 8] = pb[8*i + k];
                exp_lane.push_back(5'(i % RL));
                exp_data.push_back(d);
            end
            exp_perms = p / R;
        end else begin
            for (int i = 0; i < nw; i++) begin
                exp_lane.push_back(5'(i % RL));
                exp_data.push_back(words[i]);
            end
            exp_perms = (nw + RL - 1) / RL;
        end
    endtask

    task automatic run_msg(input int len, input int vpct);
        int nw, widx, perms, cd;
        bit got_done, saw_ready, first;
        nw = (len + 7) / 8;
        for (int i = 0; i < nw; i++) words[i] = {$urandom, $urandom};
        if (len == 5) words[0] = 64'h1122_3344_5566_7788;
        build_model(len);
        @(posedge clk); #1;
        start = 1'b1; msg_len = 32'(len); in_valid = 1'b0;
        @(posedge clk); #1;
        start = 1'b0; msg_len = $urandom;
        widx = 0; perms = 0; cd = 0; got_done = 0; saw_ready = 0; first = 1;
        for (int cyc = 0; cyc < 4000 && !got_done; cyc++) begin
            in_valid  = (widx < nw) && ($urandom_range(0, 99) < vpct);
            in_data   = in_valid ? words[widx] : {$urandom, $urandom};
            perm_done = (cd == 1) || (cd == 0 && $urandom_range(0, 3) == 0);
            if (cd > 0) cd--;
            start     = (perms < exp_perms) && ($urandom_range(0, 7) == 0);
            msg_len   = 32'd3;
            @(negedge clk);
            if (first) check("busy_after_start", busy, !(PAD == 0 && len == 0));
            first = 0;
            if (in_ready) saw_ready = 1;
            if (absorb_valid) begin
                if (exp_lane.size() == 0) begin
                    check("extra_write", absorb_valid, 0);
                end else begin
                    check($sformatf("lane_idx_len%0d", len), absorb_lane, exp_lane.pop_front());
                    check($sformatf("lane_data_len%0d", len), absorb_data, exp_data.pop_front());
                end
            end
            if (in_valid && in_ready) widx++;
            if (perm_start) begin
                perms++;
                cd = $urandom_range(1, 3);
            end
            if (done) begin
                got_done = 1;
                check("busy_at_done", busy, 0);
            end
            @(posedge clk); #1;
        end
        start = 1'b0; in_valid = 1'b0; perm_done = 1'b0;
        check($sformatf("done_seen_len%0d", len), got_done, 1);
        check($sformatf("perm_count_len%0d", len), perms, exp_perms);
        check($sformatf("missing_writes_len%0d", len), exp_lane.size(), 0);
        check($sformatf("words_taken_len%0d", len), widx, nw);
        if (len == 0) check("no_ready_len0", saw_ready, 0);
        @(negedge clk);
        check("done_one_cycle", done, 0);
        check("idle_after_done", busy, 0);
    endtask

    task automatic reset_mid_message();
        bit seen;
        seen = 0;
        @(posedge clk); #1;
        start = 1'b1; msg_len = 32'd200;
        @(posedge clk); #1;
        start = 1'b0;
        for (int cyc = 0; cyc < 100 && !seen; cyc++) begin
            in_valid = 1'b1;
            in_data  = {$urandom, $urandom};
            @(negedge clk);
            if (perm_start) seen = 1;
            else begin
                @(posedge clk); #1;
            end
        end
        check("perm_before_reset", seen, 1);
        @(posedge clk); #1;
        rst = 1'b1; in_valid = 1'b0;
        @(posedge clk); #1;
        rst = 1'b0;
        @(negedge clk);
        check("rst_busy", busy, 0);
        check("rst_in_ready", in_ready, 0);
        for (int i = 0; i < 4; i++) begin
            perm_done = 1'b1;
            @(negedge clk);
            check("rst_no_done", done, 0);
        end
        perm_done = 1'b0;
    endtask

    initial begin
        rst = 1'b1; start = 1'b0; msg_len = '0; in_valid = 1'b0;
        in_data = '0; perm_done = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_busy0", busy, 0);
        check("rst_in_ready0", in_ready, 0);
        check("rst_absorb_valid", absorb_valid, 0);
        check("rst_absorb_lane", absorb_lane, 0);
        check("rst_absorb_data", absorb_data, 0);
        check("rst_perm_start", perm_start, 0);
        check("rst_done", done, 0);
        @(posedge clk); #1;
        rst = 1'b0;

        run_msg(0, 100);
        run_msg(5, 100);
        run_msg(168, 100);
        run_msg(167, 100);
        run_msg(336, 100);
        run_msg(100, 50);
        reset_mid_message();
        run_msg(8, 100);
        for (int t = 0; t < 6; t++) run_msg($urandom_range(1, 400), $urandom_range(30, 100));

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
